axi_user_regs_gen: RTL and testbench

Parametrised AXI4-Lite register slave for the user/status register space: a configurable bank of read-only status words, a magic word and a bank of read/write control words with per-register update notification. AW and W channels are accepted independently, unmapped or read-only accesses return SLVERR, and an optional snapshot gives coherent multi-word status reads. It sits on the host AXI-Lite interconnect and replaces fixed-size status/control register blocks.

---
 rtl/axi_user_regs_pkg.sv | 43 ++++
 rtl/axi_user_regs_wr_chan.sv | 74 +++++++
 rtl/axi_user_regs_gen.sv | 175 +++++++++++++++++
 tb/tb_axi_user_regs_gen.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_user_regs_pkg.sv
// Shared constants, types and word-index decode for the AXI-Lite user register slave.
package axi_user_regs_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned STRB_W = WORD_W / 8;

  localparam logic [1:0]        RESP_OKAY     = 2'b00;
  localparam logic [1:0]        RESP_SLVERR   = 2'b10;
  localparam logic [WORD_W-1:0] DEFAULT_MAGIC = 32'h11a6ebf8;

  typedef enum logic [1:0] {
    KIND_STATUS,
    KIND_MAGIC,
    KIND_CTRL,
    KIND_UNMAPPED
  } reg_kind_e;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } wr_beat_t;

  // Status words first, then the magic word, then the control bank.
  function automatic reg_kind_e decode_word(input int unsigned idx,
                                            input int unsigned num_status,
                                            input int unsigned num_ctrl);
    if (idx < num_status) return KIND_STATUS;
    if (idx == num_status) return KIND_MAGIC;
    if (idx < num_status + 1 + num_ctrl) return KIND_CTRL;
    return KIND_UNMAPPED;
  endfunction

  function automatic logic [WORD_W-1:0] apply_strb(input logic [WORD_W-1:0] old_word,
                                                   input wr_beat_t          beat);
    logic [WORD_W-1:0] merged;
    merged = old_word;
    for (int unsigned b = 0; b < STRB_W; b++) begin
      if (beat.strb[b]) merged[b*8 +: 8] = beat.data[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi_user_regs_wr_chan.sv
// AXI-Lite write channel: independent AW/W hold registers, commit strobe and B response.
module axi_user_regs_wr_chan
  import axi_user_regs_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [WORD_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [1:0]        decode_resp,
  output logic              commit_c,
  output logic [ADDR_W-1:0] held_addr,
  output wr_beat_t          held_beat
);

  logic aw_full_q, w_full_q, bvalid_q, awready_q, wready_q;
  logic aw_full_d, w_full_d, bvalid_d;
  logic [1:0] bresp_q;

  assign commit_c = aw_full_q && w_full_q;

  // Hold-register occupancy and response state for the next cycle.
  always_comb begin
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    bvalid_d  = bvalid_q;
    if (commit_c) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
    end else begin
      if (awvalid && awready_q) aw_full_d = 1'b1;
      if (wvalid && wready_q)   w_full_d  = 1'b1;
    end
    if (bvalid_q && bready) bvalid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      held_addr <= '0;
      held_beat <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      bvalid_q  <= bvalid_d;
      awready_q <= !aw_full_d && !bvalid_d;
      wready_q  <= !w_full_d && !bvalid_d;
      if (awvalid && awready_q) held_addr <= awaddr;
      if (wvalid && wready_q)   held_beat <= '{data: wdata, strb: wstrb};
      if (commit_c)             bresp_q   <= decode_resp;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

endmodule

// File: rtl/axi_user_regs_gen.sv
// AXI4-Lite user register slave: status words, magic word, control bank with update notify.
// Optional coherent status snapshot when USER_REGS_SNAPSHOT_EN is defined.
module axi_user_regs_gen
  import axi_user_regs_pkg::*;
#(
  parameter int unsigned                C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned                C_S_AXI_ADDR_WIDTH = 8,
  parameter int unsigned                NUM_STATUS         = 13,
  parameter int unsigned                NUM_CTRL           = 4,
  parameter logic [NUM_CTRL*32-1:0]     CTRL_RESET         = '0,
  parameter logic [31:0]                MAGIC              = DEFAULT_MAGIC
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [NUM_STATUS*32-1:0]        status_in,
  output logic [NUM_CTRL*32-1:0]          ctrl_out,
  output logic [NUM_CTRL-1:0]             ctrl_wr_pulse,
  output logic [NUM_CTRL-1:0]             ctrl_wr_toggle,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int unsigned CTRL_BASE = NUM_STATUS + 1;
  localparam int unsigned AW        = C_S_AXI_ADDR_WIDTH;

  logic                 commit_c;
  logic [AW-1:0]        held_addr;
  wr_beat_t             held_beat;
  int unsigned          wr_idx;
  reg_kind_e            wr_kind;
  logic [1:0]           wr_resp_c;

  logic [NUM_CTRL*32-1:0] ctrl_q;
  logic [NUM_CTRL-1:0]    pulse_q, toggle_q;

  int unsigned            rd_idx;
  reg_kind_e              rd_kind;
  logic                   ar_hs, arready_q, rvalid_q, rvalid_d;
  logic [31:0]            rd_data_c, rdata_q;
  logic [1:0]             rd_resp_c, rresp_q;
  logic [NUM_STATUS*32-1:0] status_view_c;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{held_addr[1:0], S_AXI_ARADDR[1:0]};

  axi_user_regs_wr_chan #(.ADDR_W(AW)) u_wr_chan (
    .clk         (S_AXI_ACLK),
    .rst_n       (S_AXI_ARESETN),
    .awaddr      (S_AXI_AWADDR),
    .awvalid     (S_AXI_AWVALID),
    .awready     (S_AXI_AWREADY),
    .wdata       (S_AXI_WDATA),
    .wstrb       (S_AXI_WSTRB),
    .wvalid      (S_AXI_WVALID),
    .wready      (S_AXI_WREADY),
    .bresp       (S_AXI_BRESP),
    .bvalid      (S_AXI_BVALID),
    .bready      (S_AXI_BREADY),
    .decode_resp (wr_resp_c),
    .commit_c    (commit_c),
    .held_addr   (held_addr),
    .held_beat   (held_beat)
  );

  assign wr_idx    = 32'(held_addr[AW-1:2]);
  assign wr_kind   = decode_word(wr_idx, NUM_STATUS, NUM_CTRL);
  assign wr_resp_c = (wr_kind == KIND_CTRL) ? RESP_OKAY : RESP_SLVERR;

  // Control bank; every OKAY commit pulses and toggles its word, even with no strobes.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ctrl_q   <= CTRL_RESET;
      pulse_q  <= '0;
      toggle_q <= '0;
    end else begin
      pulse_q <= '0;
      if (commit_c && wr_kind == KIND_CTRL) begin
        for (int unsigned k = 0; k < NUM_CTRL; k++) begin
          if (wr_idx == CTRL_BASE + k) begin
            ctrl_q[k*32 +: 32] <= apply_strb(ctrl_q[k*32 +: 32], held_beat);
            pulse_q[k]         <= 1'b1;
            toggle_q[k]        <= ~toggle_q[k];
          end
        end
      end
    end
  end

  assign ctrl_out       = ctrl_q;
  assign ctrl_wr_pulse  = pulse_q;
  assign ctrl_wr_toggle = toggle_q;

  assign ar_hs   = S_AXI_ARVALID && arready_q;
  assign rd_idx  = 32'(S_AXI_ARADDR[AW-1:2]);
  assign rd_kind = decode_word(rd_idx, NUM_STATUS, NUM_CTRL);

`ifdef USER_REGS_SNAPSHOT_EN
  logic [NUM_STATUS*32-1:0] shadow_q;
  logic                     unused_shadow0;

  // A read of status word 0 freezes the whole status bank for the following reads.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN)             shadow_q <= '0;
    else if (ar_hs && rd_idx == 0)  shadow_q <= status_in;
  end

  assign unused_shadow0 = ^shadow_q[31:0];

  always_comb begin
    status_view_c        = shadow_q;
    status_view_c[31:0]  = status_in[31:0];
  end
`else
  assign status_view_c = status_in;
`endif

  // Read decode, sampled on the AR handshake edge.
  always_comb begin
    rd_data_c = '0;
    rd_resp_c = RESP_OKAY;
    unique case (rd_kind)
      KIND_STATUS: begin
        for (int unsigned k = 0; k < NUM_STATUS; k++) begin
          if (rd_idx == k) rd_data_c = status_view_c[k*32 +: 32];
        end
      end
      KIND_MAGIC: rd_data_c = MAGIC;
      KIND_CTRL: begin
        for (int unsigned k = 0; k < NUM_CTRL; k++) begin
          if (rd_idx == CTRL_BASE + k) rd_data_c = ctrl_q[k*32 +: 32];
        end
      end
      default: rd_resp_c = RESP_SLVERR;
    endcase
  end

  assign rvalid_d = ar_hs || (rvalid_q && !S_AXI_RREADY);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      rvalid_q  <= rvalid_d;
      arready_q <= !rvalid_d;
      if (ar_hs) begin
        rdata_q <= rd_data_c;
        rresp_q <= rd_resp_c;
      end
    end
  end

  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_user_regs_gen.sv
// Randomised self-checking bench for axi_user_regs_gen against an array-based register model.
module tb_axi_user_regs_gen;

  localparam int unsigned NS      = 13;
  localparam int unsigned NC      = 4;
  localparam int unsigned TIMEOUT = 64;
  localparam logic [31:0] MAGIC_V = 32'h11a6ebf8;
  localparam logic [1:0]  OKAY    = 2'b00;
  localparam logic [1:0]  SLVERR  = 2'b10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NS*32-1:0] status_in = '0;
  logic [NC*32-1:0] ctrl_out;
  logic [NC-1:0]    pulse, toggle;
  logic [7:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [31:0] wdata = '0, rdata;
  logic [3:0]  wstrb = '0;
  logic [1:0]  bresp, rresp;

  logic [31:0] status_m [NS];
  logic [31:0] shadow_m [NS];
  logic [31:0] ctrl_m   [NC];
  int unsigned wr_cnt   [NC];
  int errors = 0;
  int checks = 0;

  axi_user_regs_gen dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .status_in(status_in), .ctrl_out(ctrl_out),
    .ctrl_wr_pulse(pulse), .ctrl_wr_toggle(toggle),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NC*32-1:0] ctrl_vec();
    logic [NC*32-1:0] v;
    for (int k = 0; k < NC; k++) v[k*32 +: 32] = ctrl_m[k];
    return v;
  endfunction

  function automatic logic [NC-1:0] toggle_vec();
    logic [NC-1:0] v;
    for (int k = 0; k < NC; k++) v[k] = wr_cnt[k][0];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin ctrl_m[k] = '0; wr_cnt[k] = 0; end
    for (int k = 0; k < NS; k++) shadow_m[k] = '0;
  endtask

  task automatic set_status(input int unsigned idx, input logic [31:0] val);
    status_m[idx] = val;
    status_in[idx*32 +: 32] = val;
  endtask

  task automatic drive_aw(input logic [7:0] a, input int dly);
    int n = 0;
    repeat (dly) @(negedge clk);
    awaddr = a; awvalid = 1'b1;
    while (!awready && n < TIMEOUT) begin @(negedge clk); n++; end
    check("aw_ready", awready, 1);
    @(negedge clk); awvalid = 1'b0;
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    int n = 0;
    repeat (dly) @(negedge clk);
    wdata = d; wstrb = s; wvalid = 1'b1;
    while (!wready && n < TIMEOUT) begin @(negedge clk); n++; end
    check("w_ready", wready, 1);
    @(negedge clk); wvalid = 1'b0;
  endtask

  // b_dly < 0 leaves the response pending (BREADY low).
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp);
    int unsigned idx;
    logic is_ctrl;
    logic [NC-1:0] exp_pulse;
    idx = 32'(a[7:2]);
    is_ctrl = (idx >= NS + 1) && (idx < NS + 1 + NC);
    fork
      drive_aw(a, aw_dly);
      drive_w(d, s, w_dly);
    join
    check("b_latency", bvalid, 0);
    exp_pulse = '0;
    if (is_ctrl) begin
      for (int b = 0; b < 4; b++) if (s[b]) ctrl_m[idx-NS-1][8*b +: 8] = d[8*b +: 8];
      wr_cnt[idx-NS-1]++;
      exp_pulse[idx-NS-1] = 1'b1;
    end
    @(negedge clk);
    check("bvalid", bvalid, 1);
    check("bresp", bresp, is_ctrl ? OKAY : SLVERR);
    check("pulse", pulse, exp_pulse);
    check("ctrl_out", ctrl_out, ctrl_vec());
    check("toggle", toggle, toggle_vec());
    check("wr_busy", {awready, wready}, 2'b00);
    resp = bresp;
    if (b_dly >= 0) begin
      for (int i = 0; i < b_dly; i++) begin
        @(negedge clk);
        check("b_hold", {bvalid, awready, wready}, 3'b100);
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      check("b_done", {bvalid, awready, wready, pulse}, {3'b011, {NC{1'b0}}});
    end
  endtask

  // r_dly < 0 leaves the read data pending (RREADY low).
  task automatic axi_read(input logic [7:0] a, input int r_dly, output logic [31:0] d);
    int unsigned idx;
    int n = 0;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    idx = 32'(a[7:2]);
    araddr = a; arvalid = 1'b1;
    while (!arready && n < TIMEOUT) begin @(negedge clk); n++; end
    check("ar_ready", arready, 1);
    exp_d = '0; exp_r = OKAY;
    if (idx < NS) begin
`ifdef USER_REGS_SNAPSHOT_EN
      if (idx == 0) begin
        for (int k = 0; k < NS; k++) shadow_m[k] = status_m[k];
        exp_d = status_m[0];
      end else exp_d = shadow_m[idx];
`else
      exp_d = status_m[idx];
`endif
    end else if (idx == NS) exp_d = MAGIC_V;
    else if (idx < NS + 1 + NC) exp_d = ctrl_m[idx-NS-1];
    else exp_r = SLVERR;
    @(negedge clk);
    arvalid = 1'b0;
    check("rvalid", {rvalid, arready}, 2'b10);
    check("rdata", rdata, exp_d);
    check("rresp", rresp, exp_r);
    d = rdata;
    if (r_dly >= 0) begin
      for (int i = 0; i < r_dly; i++) begin
        @(negedge clk);
        check("r_hold", {rvalid, arready, rdata}, {2'b10, exp_d});
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      check("r_done", {rvalid, arready}, 2'b01);
    end
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] d;
    logic [7:0]  a;
    for (int k = 0; k < NS; k++) set_status(k, $urandom);
    model_reset();

    repeat (3) @(negedge clk);
    check("rst_ready", {awready, wready, arready, bvalid, rvalid}, 5'b0);
    check("rst_ctrl", ctrl_out, '0);
    check("rst_notify", {pulse, toggle}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {awready, wready, arready}, 3'b111);

    axi_read(8'h34, 0, d);
    check("magic", d, MAGIC_V);
    check("ctrl_reset", ctrl_out, '0);

    axi_write(8'h3C, 32'hA5A5A5A5, 4'b0101, 0, 3, 0, resp);
    check("ctrl1_merge", ctrl_out[63:32], 32'h00A500A5);
    check("toggle1", toggle[1], 1'b1);

    axi_write(8'h38, $urandom, 4'hF, 1, 0, 5, resp);
    axi_write(8'h40, $urandom, 4'hF, 0, 0, 0, resp);
    axi_write(8'h44, 32'h12345678, 4'h0, 0, 1, 0, resp);

    axi_write(8'h00, 32'hFFFFFFFF, 4'hF, 0, 0, 0, resp);
    check("status_wr_slverr", resp, SLVERR);
    axi_write(8'h48, 32'hFFFFFFFF, 4'hF, 2, 0, 1, resp);
    check("unmapped_wr_slverr", resp, SLVERR);
    axi_read(8'h48, 1, d);
    check("unmapped_rd_zero", d, 32'h0);

    set_status(1, 32'h1);
    axi_read(8'h00, 0, d);
    set_status(1, 32'h2);
    axi_read(8'h04, 0, d);
`ifdef USER_REGS_SNAPSHOT_EN
    check("snapshot_word1", d, 32'h1);
`else
    check("snapshot_word1", d, 32'h2);
`endif

    for (int i = 0; i < 120; i++) begin
      a = 8'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: set_status($urandom_range(0, NS - 1), $urandom);
        1, 2: axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                        $urandom_range(0, 3), $urandom_range(0, 3), resp);
        default: axi_read(a, $urandom_range(0, 2), d);
      endcase
    end

    axi_write(8'h38, 32'hDEADBEEF, 4'hF, 0, 0, -1, resp);
    axi_read(8'h34, -1, d);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {bvalid, rvalid, awready, wready, arready}, 5'b0);
    check("async_rst_resp", {rdata, rresp, bresp}, '0);
    check("async_rst_ctrl", ctrl_out, '0);
    check("async_rst_notify", {pulse, toggle}, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst2", {awready, wready, arready}, 3'b111);
    axi_read(8'h38, 0, d);
    axi_write(8'h40, 32'hCAFEF00D, 4'b1100, 0, 0, 0, resp);
    axi_read(8'h40, 0, d);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
